btn_en_conditioner: RTL and testbench

BTN_EN_CONDITIONER -- requirements
Module: btn_en_conditioner

---
 rtl/btn_en_conditioner.sv | 120 ++++++++++++
 tb/tb_btn_en_conditioner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_en_conditioner.sv
// ============================================================================
//  Module   : btn_en_conditioner
//  Purpose  : Debounces a raw push-button and steps a 4-bit enable code once
//             per accepted press, with decodes for the CountUp/CountDown codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_en_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 2000000,
  parameter logic [3:0] EN_INIT         = 4'b0000
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic [3:0] count_en,
  output logic       en_up,
  output logic       en_down
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      C_UP    = 4'b0101;
  localparam logic [3:0]      C_DOWN  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [3:0]       en_q, en_d;
  logic             s;

  assign s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], btn_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
          en_d    = en_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      ARM_RELEASE: begin
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Level follows the destination state so it changes on the same edge.
    level_d = (state_d == PRESSED) || (state_d == ARM_RELEASE);
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      en_q    <= EN_INIT;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      en_q    <= en_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign count_en  = en_q;
  assign en_up     = (en_q == C_UP);
  assign en_down   = (en_q == C_DOWN);

endmodule

`default_nettype wire

// File: tb/tb_btn_en_conditioner.sv
// ============================================================================
//  Module   : tb_btn_en_conditioner
//  Purpose  : Self-checking bench for btn_en_conditioner (DEBOUNCE_CYCLES=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_en_conditioner;

  localparam int D = 4;

  logic       gclk;
  logic       rst;
  logic       btn_in;
  logic       btn_level;
  logic       btn_pulse;
  logic [3:0] count_en;
  logic       en_up;
  logic       en_down;

  btn_en_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .EN_INIT        (4'b0000)
  ) dut (
    .gclk     (gclk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .count_en (count_en),
    .en_up    (en_up),
    .en_down  (en_down)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Reference: accepted level flips once the synchronized input has differed
  // from it on D+1 consecutive edges; a rising flip is one press.
  logic       m_sync [2];
  logic       m_lvl;
  logic       m_pulse;
  logic [3:0] m_cnt;
  int         m_run;

  typedef struct {
    logic       btn;
    logic       lvl;
    logic       pls;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync[0] = 1'b0;
    m_sync[1] = 1'b0;
    m_lvl     = 1'b0;
    m_pulse   = 1'b0;
    m_cnt     = 4'b0000;
    m_run     = 0;
  endtask

  task automatic model_step(input logic b);
    logic s_use;
    s_use     = m_sync[1];
    m_sync[1] = m_sync[0];
    m_sync[0] = b;
    m_pulse   = 1'b0;
    if (s_use == m_lvl) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == D + 1) begin
        m_lvl = ~m_lvl;
        m_run = 0;
        if (m_lvl) begin
          m_pulse = 1'b1;
          m_cnt   = m_cnt + 4'd1;
        end
      end
    end
  endtask

  task automatic tick(input logic b, input logic r);
    @(negedge gclk);
    btn_in = b;
    rst    = r;
    @(posedge gclk);
    #1;
    if (r) model_reset();
    else   model_step(b);
    check("mdl_level", btn_level, m_lvl);
    check("mdl_pulse", btn_pulse, m_pulse);
    check("mdl_count", count_en, m_cnt);
    check("mdl_en_up", en_up, m_cnt == 4'b0101);
    check("mdl_en_down", en_down, m_cnt == 4'b1010);
    if (btn_pulse) pulses++;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    pulses = 0;
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b, 1'b0);
  endtask

  task automatic press_release();
    hold(1'b1, 8);
    hold(1'b0, 12);
  endtask

  initial begin
    btn_in = 1'b0;
    rst    = 1'b1;
    model_reset();

    for (int i = 0; i < 22; i++) begin
      vecs[i].btn = (i < 12);
      vecs[i].lvl = (i >= 6) && (i < 18);
      vecs[i].pls = (i == 6);
      vecs[i].cnt = (i >= 6) ? 4'b0001 : 4'b0000;
    end

    // Reset state
    do_reset();
    check("rst_level", btn_level, 1'b0);
    check("rst_pulse", btn_pulse, 1'b0);
    check("rst_count", count_en, 4'b0000);
    check("rst_en_up", en_up, 1'b0);
    check("rst_en_down", en_down, 1'b0);

    // Clean press: pulse at edge 7, release level drop at edge 19
    for (int i = 0; i < 22; i++) begin
      tick(vecs[i].btn, 1'b0);
      check("vec_level", btn_level, vecs[i].lvl);
      check("vec_pulse", btn_pulse, vecs[i].pls);
      check("vec_count", count_en, vecs[i].cnt);
    end

    // Bounce on press
    do_reset();
    hold(1'b1, 3);
    hold(1'b0, 1);
    hold(1'b1, 20);
    hold(1'b0, 12);
    check("bounce_pulses", pulses, 1);
    check("bounce_count", count_en, 4'b0001);

    // Short glitch alone
    do_reset();
    hold(1'b1, 3);
    hold(1'b0, 15);
    check("glitch_pulses", pulses, 0);
    check("glitch_count", count_en, 4'b0000);

    // Repeated presses and wrap
    do_reset();
    for (int i = 0; i < 5; i++) press_release();
    check("rep5_count", count_en, 4'b0101);
    check("rep5_en_up", en_up, 1'b1);
    check("rep5_en_down", en_down, 1'b0);
    for (int i = 0; i < 5; i++) press_release();
    check("rep10_count", count_en, 4'b1010);
    check("rep10_en_up", en_up, 1'b0);
    check("rep10_en_down", en_down, 1'b1);
    for (int i = 0; i < 6; i++) press_release();
    check("rep16_count", count_en, 4'b0000);
    check("rep16_pulses", pulses, 16);

    // Release bounce
    do_reset();
    hold(1'b1, 10);
    hold(1'b0, 2);
    hold(1'b1, 10);
    check("relb_level", btn_level, 1'b1);
    check("relb_pulses", pulses, 1);
    hold(1'b0, 12);
    check("relb_final_level", btn_level, 1'b0);

    // Async reset mid-debounce with count_en = 3
    do_reset();
    for (int i = 0; i < 3; i++) press_release();
    check("ar_pre_count", count_en, 4'b0011);
    hold(1'b1, 4);
    #2;
    rst = 1'b1;
    #1;
    check("ar_level", btn_level, 1'b0);
    check("ar_pulse", btn_pulse, 1'b0);
    check("ar_count", count_en, 4'b0000);
    pulses = 0;
    tick(1'b1, 1'b1);
    hold(1'b1, 12);
    check("ar_repress_pulses", pulses, 1);
    check("ar_repress_count", count_en, 4'b0001);
    hold(1'b0, 12);

    // Held button
    do_reset();
    hold(1'b1, 100);
    check("held_pulses", pulses, 1);
    check("held_level", btn_level, 1'b1);
    hold(1'b0, 12);

    // Randomized runs against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic b;
      int   n;
      b = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 9);
      if ($urandom_range(0, 49) == 0) tick(b, 1'b1);
      for (int k = 0; k < n; k++) tick(b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
